btn_count_ctrl: RTL and testbench

BTN_COUNT_CTRL -- requirements
Module: btn_count_ctrl

---
 rtl/btn_count_ctrl_pkg.sv | 26 ++
 rtl/btn_debounce.sv | 53 +++++
 rtl/btn_count_ctrl.sv | 174 +++++++++++++++++
 tb/tb_btn_count_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_count_ctrl_pkg.sv
// ============================================================================
// Package : btn_count_ctrl_pkg
// Brief   : Shared constants for the button-to-counter command controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package btn_count_ctrl_pkg;

  localparam int c_val_w          = 5;
  localparam int c_db_cycles_def  = 4;
  localparam int c_rpt_delay_def  = 16;
  localparam int c_rpt_rate_def   = 4;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_first  = 2'd1;
  localparam logic [1:0] c_st_delay  = 2'd2;
  localparam logic [1:0] c_st_repeat = 2'd3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module : btn_debounce
// Brief  : Two-flop synchronizer followed by a consecutive-mismatch debouncer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_debounce
  import btn_count_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = c_db_cycles_def
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db
);

  localparam int c_cnt_w = $clog2(DB_CYCLES + 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_db;
  logic [c_cnt_w-1:0] r_cnt;

  // Level flips on the edge after DB_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_db) begin
        if (r_cnt == c_cnt_w'(DB_CYCLES)) begin
          r_db  <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign btn_db = r_db;

endmodule

`default_nettype wire

// File: rtl/btn_count_ctrl.sv
// ============================================================================
// Module : btn_count_ctrl
// Brief  : Debounced up/down/load buttons to one-cycle counter commands with
//          auto-repeat, boundary suppression and load priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_count_ctrl
  import btn_count_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = c_db_cycles_def,
  parameter int RPT_DELAY = c_rpt_delay_def,
  parameter int RPT_RATE  = c_rpt_rate_def
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_btn,
  input  logic               dn_btn,
  input  logic               load_btn,
  input  logic [c_val_w-1:0] load_val,
  input  logic               high,
  input  logic               low,
  output logic               up,
  output logic               down,
  output logic               load,
  output logic [c_val_w-1:0] in_val
);

  localparam int c_tmr_w = $clog2(max2(RPT_DELAY, RPT_RATE) + 1);

  logic [2:0]         w_raw;
  logic [2:0]         w_db;
  logic [2:0]         r_db_q;
  logic [2:0]         w_rise;
  logic               w_conflict;
  logic               w_held;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               r_dir;
  logic               w_dir_nxt;
  logic [c_tmr_w-1:0] r_tmr;
  logic [c_tmr_w-1:0] w_tmr_nxt;
  logic               w_fire;

  logic               r_up;
  logic               r_dn;
  logic               r_ld;
  logic [c_val_w-1:0] r_in_val;
  logic               w_up_nxt;
  logic               w_dn_nxt;
  logic               w_ld_nxt;
  logic [c_val_w-1:0] w_val_nxt;

  // Bit 0 = up, bit 1 = down, bit 2 = load.
  assign w_raw = {load_btn, dn_btn, up_btn};

  for (genvar gi = 0; gi < 3; gi++) begin : g_db
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (w_raw[gi]),
      .btn_db  (w_db[gi])
    );
  end

  assign w_rise     = w_db & ~r_db_q;
  assign w_conflict = w_db[0] & w_db[1];
  assign w_held     = r_dir ? w_db[1] : w_db[0];

  always_ff @(posedge clk or posedge rst) begin : p_reg
    if (rst) begin
      r_state  <= c_st_idle;
      r_dir    <= 1'b0;
      r_tmr    <= '0;
      r_db_q   <= '0;
      r_up     <= 1'b0;
      r_dn     <= 1'b0;
      r_ld     <= 1'b0;
      r_in_val <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_dir    <= w_dir_nxt;
      r_tmr    <= w_tmr_nxt;
      r_db_q   <= w_db;
      r_up     <= w_up_nxt;
      r_dn     <= w_dn_nxt;
      r_ld     <= w_ld_nxt;
      r_in_val <= w_val_nxt;
    end
  end

  // Timer counts cycles since the last pulse; it is cleared on every pulse.
  always_comb begin : p_next
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_tmr_nxt   = r_tmr;
    w_fire      = 1'b0;
    if (w_rise[2] || w_conflict) begin
      w_state_nxt = c_st_idle;
      w_tmr_nxt   = '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          w_tmr_nxt = '0;
          if (w_rise[0]) begin
            w_state_nxt = c_st_first;
            w_dir_nxt   = 1'b0;
            w_fire      = 1'b1;
          end else if (w_rise[1]) begin
            w_state_nxt = c_st_first;
            w_dir_nxt   = 1'b1;
            w_fire      = 1'b1;
          end
        end
        c_st_first: begin
          if (!w_held) begin
            w_state_nxt = c_st_idle;
            w_tmr_nxt   = '0;
          end else begin
            w_state_nxt = c_st_delay;
            w_tmr_nxt   = c_tmr_w'(1);
          end
        end
        c_st_delay: begin
          if (!w_held) begin
            w_state_nxt = c_st_idle;
            w_tmr_nxt   = '0;
          end else if (r_tmr == c_tmr_w'(RPT_DELAY - 1)) begin
            w_state_nxt = c_st_repeat;
            w_tmr_nxt   = '0;
            w_fire      = 1'b1;
          end else begin
            w_tmr_nxt   = r_tmr + c_tmr_w'(1);
          end
        end
        c_st_repeat: begin
          if (!w_held) begin
            w_state_nxt = c_st_idle;
            w_tmr_nxt   = '0;
          end else if (r_tmr == c_tmr_w'(RPT_RATE - 1)) begin
            w_tmr_nxt   = '0;
            w_fire      = 1'b1;
          end else begin
            w_tmr_nxt   = r_tmr + c_tmr_w'(1);
          end
        end
        default: begin
          w_state_nxt = c_st_idle;
          w_tmr_nxt   = '0;
        end
      endcase
    end
  end

  // Load never coincides with w_fire, so the three commands stay exclusive.
  always_comb begin : p_out
    w_up_nxt  = w_fire & ~w_dir_nxt & ~high;
    w_dn_nxt  = w_fire &  w_dir_nxt & ~low;
    w_ld_nxt  = w_rise[2];
    w_val_nxt = w_rise[2] ? load_val : r_in_val;
  end

  assign up     = r_up;
  assign down   = r_dn;
  assign load   = r_ld;
  assign in_val = r_in_val;

endmodule

`default_nettype wire

// File: tb/tb_btn_count_ctrl.sv
// ============================================================================
// Module : tb_btn_count_ctrl
// Brief  : Directed self-checking bench for btn_count_ctrl (default params).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_btn_count_ctrl;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       up_btn   = 1'b0;
  logic       dn_btn   = 1'b0;
  logic       load_btn = 1'b0;
  logic [4:0] load_val = 5'd0;
  logic       high     = 1'b0;
  logic       low      = 1'b0;
  logic       up;
  logic       down;
  logic       load;
  logic [4:0] in_val;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_err  = 0;
  int n_excl = 0;
  int up_q[$];
  int dn_q[$];
  int ld_q[$];
  int val_q[$];

  always #5 clk = ~clk;

  btn_count_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .up_btn   (up_btn),
    .dn_btn   (dn_btn),
    .load_btn (load_btn),
    .load_val (load_val),
    .high     (high),
    .low      (low),
    .up       (up),
    .down     (down),
    .load     (load),
    .in_val   (in_val)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n edges, logging the edge index of every command pulse.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (up)   up_q.push_back(cyc);
      if (down) dn_q.push_back(cyc);
      if (load) begin
        ld_q.push_back(cyc);
        val_q.push_back(int'(in_val));
      end
      if ((int'(up) + int'(down) + int'(load)) > 1) n_excl++;
    end
  endtask

  task automatic clear_logs();
    up_q.delete();
    dn_q.delete();
    ld_q.delete();
    val_q.delete();
  endtask

  initial begin
    int p;
    int q;
    int r;
    int exp_rep[7];
    int exp_dn[4];
    exp_rep = '{8, 24, 28, 32, 36, 40, 44};
    exp_dn  = '{8, 24, 28, 32};

    // Reset state
    step(3);
    check_eq("rst_up", up, 0);
    check_eq("rst_down", down, 0);
    check_eq("rst_load", load, 0);
    check_eq("rst_in_val", in_val, 0);
    rst = 1'b0;
    step(5);

    // Single tap: raw high 10 cycles, first sample edge p+1, pulse at p+8
    clear_logs();
    p = cyc;
    up_btn = 1'b1;
    step(10);
    up_btn = 1'b0;
    step(30);
    check_eq("tap_count", up_q.size(), 1);
    check_eq("tap_edge", (up_q.size() > 0) ? up_q[0] - p : -1, 8);

    // Auto-repeat: held 40 cycles
    clear_logs();
    p = cyc;
    up_btn = 1'b1;
    step(40);
    up_btn = 1'b0;
    step(30);
    check_eq("rep_count", up_q.size(), 7);
    for (int i = 0; i < 7; i++)
      check_eq($sformatf("rep_edge%0d", i), (up_q.size() > i) ? up_q[i] - p : -1, exp_rep[i]);

    // Bounce: toggles every 2 cycles
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      up_btn = (i % 2 == 0);
      step(2);
    end
    up_btn = 1'b0;
    step(20);
    check_eq("bounce_count", up_q.size(), 0);

    // Boundary suppression
    clear_logs();
    high = 1'b1;
    up_btn = 1'b1;
    step(30);
    up_btn = 1'b0;
    step(15);
    high = 1'b0;
    check_eq("high_sup", up_q.size(), 0);
    low = 1'b1;
    dn_btn = 1'b1;
    step(30);
    dn_btn = 1'b0;
    step(15);
    low = 1'b0;
    check_eq("low_sup", dn_q.size(), 0);

    // Load during down REPEAT
    clear_logs();
    load_val = 5'd19;
    p = cyc;
    dn_btn = 1'b1;
    step(26);
    load_btn = 1'b1;
    step(8);
    load_btn = 1'b0;
    step(20);
    check_eq("ld_dn_count", dn_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("ld_dn_edge%0d", i), (dn_q.size() > i) ? dn_q[i] - p : -1, exp_dn[i]);
    check_eq("ld_count", ld_q.size(), 1);
    check_eq("ld_edge", (ld_q.size() > 0) ? ld_q[0] - p : -1, 34);
    check_eq("ld_in_val", (val_q.size() > 0) ? val_q[0] : -1, 19);
    dn_btn = 1'b0;
    step(15);
    check_eq("ld_no_dn_held", dn_q.size(), 4);
    q = cyc;
    dn_btn = 1'b1;
    step(10);
    dn_btn = 1'b0;
    step(15);
    check_eq("repress_count", dn_q.size(), 5);
    check_eq("repress_edge", (dn_q.size() > 4) ? dn_q[4] - q : -1, 8);

    // Reset mid-DELAY with button held
    clear_logs();
    p = cyc;
    up_btn = 1'b1;
    step(12);
    rst = 1'b1;
    #1;
    check_eq("midrst_up", up, 0);
    check_eq("midrst_down", down, 0);
    check_eq("midrst_load", load, 0);
    check_eq("midrst_in_val", in_val, 0);
    step(3);
    rst = 1'b0;
    r = cyc;
    step(12);
    up_btn = 1'b0;
    step(15);
    check_eq("midrst_count", up_q.size(), 2);
    check_eq("midrst_first", (up_q.size() > 0) ? up_q[0] - p : -1, 8);
    check_eq("midrst_after", (up_q.size() > 1) ? up_q[1] - r : -1, 8);

    check_eq("exclusive", n_excl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
